// File: rtl/mvm_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : mvm_pkg
// Brief    : Shared FSM state type and width helpers for mat_vec_mac_seq.
// Revision : 1.0
// ----------------------------------------------------------------------------
package mvm_pkg;

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_MAC  = 2'd1,
    S_OUT  = 2'd2
  } state_e;

  // Worst-case dot product of n W-bit terms fits without wrap.
  function automatic int acc_w(input int n, input int w);
    return 2 * w + $clog2(n);
  endfunction

  // Index width for counting 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mvm_mac.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : mvm_mac
// Brief    : Single multiply-accumulate lane with clear and enable.
// Revision : 1.0
// ----------------------------------------------------------------------------
module mvm_mac #(
  parameter int W      = 4,
  parameter int ACC_W  = 9,
  parameter bit SIGNED = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [W-1:0]     a_i,
  input  logic [W-1:0]     b_i,
  output logic [ACC_W-1:0] sum_o
);

  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] w_a_ext;
  logic [ACC_W-1:0] w_b_ext;
  logic [ACC_W-1:0] w_prod;

  // Extending to full accumulator width first keeps the modular product exact.
  generate
    if (SIGNED) begin : g_sext
      assign w_a_ext = {{(ACC_W-W){a_i[W-1]}}, a_i};
      assign w_b_ext = {{(ACC_W-W){b_i[W-1]}}, b_i};
    end else begin : g_zext
      assign w_a_ext = {{(ACC_W-W){1'b0}}, a_i};
      assign w_b_ext = {{(ACC_W-W){1'b0}}, b_i};
    end
  endgenerate

  assign w_prod = w_a_ext * w_b_ext;
  assign sum_o  = acc_q + w_prod;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      acc_q <= '0;
    end else if (en) begin
      acc_q <= sum_o;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mat_vec_mac_seq.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : mat_vec_mac_seq
// Brief    : Sequential N x N matrix times N-vector using one shared MAC lane.
// Revision : 1.0
// ----------------------------------------------------------------------------
module mat_vec_mac_seq
  import mvm_pkg::*;
#(
  parameter  int N      = 2,
  parameter  int W      = 4,
  parameter  bit SIGNED = 1'b0,
  localparam int ACC_W  = acc_w(N, W),
  localparam int AW     = cnt_w(N * N),
  localparam int CW     = cnt_w(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mat_wr_en,
  input  logic [AW-1:0]    mat_wr_addr,
  input  logic [W-1:0]     mat_wr_data,
  input  logic             vec_valid,
  output logic             vec_ready,
  input  logic [W-1:0]     vec_data,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [ACC_W-1:0] res_data,
  output logic             res_last,
  output logic             busy,
  output logic             wr_err
);

  state_e           state_q, state_d;
  logic [CW-1:0]    vcnt_q;
  logic [CW-1:0]    row_q;
  logic [CW-1:0]    col_q;
  logic [W-1:0]     m_q [N*N];
  logic [W-1:0]     v_q [N];
  logic [ACC_W-1:0] result_q;
  logic             wr_err_q;

  logic [ACC_W-1:0] w_sum;
  logic [AW-1:0]    w_m_idx;
  logic             w_vec_hs;
  logic             w_wr_win;
  logic             w_addr_ok;
  logic             w_last_v;
  logic             w_last_col;
  logic             w_last_row;
  logic             w_mac_clr;
  logic             w_mac_en;

  assign w_vec_hs   = vec_valid && vec_ready;
  assign w_wr_win   = (state_q == S_LOAD) && (vcnt_q == '0);
  assign w_last_v   = (vcnt_q == CW'(N - 1));
  assign w_last_col = (col_q == CW'(N - 1));
  assign w_last_row = (row_q == CW'(N - 1));
  assign w_m_idx    = AW'(row_q) * AW'(N) + AW'(col_q);

  // Addresses past N*N only exist when N*N is not a power of two.
  generate
    if (N * N == (1 << AW)) begin : g_addr_full
      assign w_addr_ok = 1'b1;
    end else begin : g_addr_part
      assign w_addr_ok = (int'(mat_wr_addr) < N * N);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_LOAD:  if (w_vec_hs && w_last_v) state_d = S_MAC;
      S_MAC:   if (w_last_col) state_d = S_OUT;
      S_OUT:   if (res_ready) state_d = w_last_row ? S_LOAD : S_MAC;
      default: state_d = S_LOAD;
    endcase
  end

  // The accumulator is held clear outside S_MAC so every row starts from zero.
  always_comb begin
    vec_ready = 1'b0;
    res_valid = 1'b0;
    w_mac_clr = 1'b0;
    w_mac_en  = 1'b0;
    case (state_q)
      S_LOAD: begin
        vec_ready = 1'b1;
        w_mac_clr = 1'b1;
      end
      S_MAC: begin
        w_mac_en = 1'b1;
      end
      S_OUT: begin
        res_valid = 1'b1;
        w_mac_clr = 1'b1;
      end
      default: begin
        w_mac_clr = 1'b1;
      end
    endcase
  end

  assign res_last = (state_q == S_OUT) && w_last_row;
  assign res_data = result_q;
  assign busy     = (state_q != S_LOAD) || (vcnt_q != '0);
  assign wr_err   = wr_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      vcnt_q   <= '0;
      row_q    <= '0;
      col_q    <= '0;
      result_q <= '0;
      wr_err_q <= 1'b0;
      for (int i = 0; i < N * N; i++) m_q[i] <= '0;
      for (int i = 0; i < N; i++) v_q[i] <= '0;
    end else begin
      if (mat_wr_en) begin
        if (!w_wr_win) begin
          wr_err_q <= 1'b1;
        end else if (w_addr_ok) begin
          m_q[mat_wr_addr] <= mat_wr_data;
        end
      end
      case (state_q)
        S_LOAD: begin
          if (w_vec_hs) begin
            v_q[vcnt_q] <= vec_data;
            vcnt_q      <= w_last_v ? '0 : vcnt_q + CW'(1);
            row_q       <= '0;
            col_q       <= '0;
          end
        end
        S_MAC: begin
          col_q <= w_last_col ? '0 : col_q + CW'(1);
          if (w_last_col) result_q <= w_sum;
        end
        S_OUT: begin
          if (res_ready) begin
            row_q <= w_last_row ? '0 : row_q + CW'(1);
            col_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  mvm_mac #(
    .W      (W),
    .ACC_W  (ACC_W),
    .SIGNED (SIGNED)
  ) u_mac (
    .clk   (clk),
    .rst   (rst),
    .clr   (w_mac_clr),
    .en    (w_mac_en),
    .a_i   (m_q[w_m_idx]),
    .b_i   (v_q[col_q]),
    .sum_o (w_sum)
  );

endmodule
`default_nettype wire

// File: tb/tb_mat_vec_mac_seq.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : tb_mat_vec_mac_seq
// Brief    : Scoreboard bench driving an unsigned and a signed instance in lockstep.
// Revision : 1.0
// ----------------------------------------------------------------------------
module tb_mat_vec_mac_seq;

  localparam int N     = 2;
  localparam int W     = 4;
  localparam int ACC_W = 9;

  typedef struct packed {
    logic [ACC_W-1:0] d;
    logic             l;
  } exp_t;

  logic             clk         = 1'b0;
  logic             rst         = 1'b1;
  logic             mat_wr_en   = 1'b0;
  logic [1:0]       mat_wr_addr = '0;
  logic [W-1:0]     mat_wr_data = '0;
  logic             vec_valid   = 1'b0;
  logic [W-1:0]     vec_data    = '0;
  logic             res_ready   = 1'b1;
  logic             stall_en    = 1'b0;
  int               stall_cnt   = 0;

  logic             vec_ready0, res_valid0, res_last0, busy0, wr_err0;
  logic             vec_ready1, res_valid1, res_last1, busy1, wr_err1;
  logic [ACC_W-1:0] res_data0, res_data1;

  exp_t             q0[$];
  exp_t             q1[$];
  int               errors = 0;
  int               checks = 0;
  int               hs[2];
  logic             pv[2];
  logic [ACC_W-1:0] pd[2];
  logic             pl[2];

  always #5 clk = ~clk;

  mat_vec_mac_seq #(.N(N), .W(W), .SIGNED(1'b0)) u0 (
    .clk(clk), .rst(rst), .mat_wr_en(mat_wr_en), .mat_wr_addr(mat_wr_addr),
    .mat_wr_data(mat_wr_data), .vec_valid(vec_valid), .vec_ready(vec_ready0),
    .vec_data(vec_data), .res_valid(res_valid0), .res_ready(res_ready),
    .res_data(res_data0), .res_last(res_last0), .busy(busy0), .wr_err(wr_err0));

  mat_vec_mac_seq #(.N(N), .W(W), .SIGNED(1'b1)) u1 (
    .clk(clk), .rst(rst), .mat_wr_en(mat_wr_en), .mat_wr_addr(mat_wr_addr),
    .mat_wr_data(mat_wr_data), .vec_valid(vec_valid), .vec_ready(vec_ready1),
    .vec_data(vec_data), .res_valid(res_valid1), .res_ready(res_ready),
    .res_data(res_data1), .res_last(res_last1), .busy(busy1), .wr_err(wr_err1));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic mon(input int id, input logic vr, input logic rv,
                     input logic [ACC_W-1:0] rd, input logic rl);
    exp_t e;
    int   qs;
    qs = (id == 0) ? q0.size() : q1.size();
    if (rv) check($sformatf("excl%0d", id), 32'(vr), 32'(0));
    if (qs != 0) check($sformatf("no_ready_pending%0d", id), 32'(vr), 32'(0));
    if (rv && pv[id]) begin
      check($sformatf("stable_data%0d", id), 32'(rd), 32'(pd[id]));
      check($sformatf("stable_last%0d", id), 32'(rl), 32'(pl[id]));
    end
    if (rv && res_ready) begin
      hs[id]++;
      if (qs == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_res%0d: got %0h with no result expected", id, rd);
      end else begin
        if (id == 0) e = q0.pop_front();
        else         e = q1.pop_front();
        check($sformatf("res_data%0d", id), 32'(rd), 32'(e.d));
        check($sformatf("res_last%0d", id), 32'(rl), 32'(e.l));
      end
    end
    pv[id] = rv && !res_ready;
    pd[id] = rd;
    pl[id] = rl;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      pv[0] = 1'b0;
      pv[1] = 1'b0;
    end else begin
      mon(0, vec_ready0, res_valid0, res_data0, res_last0);
      mon(1, vec_ready1, res_valid1, res_data1, res_last1);
    end
  end

  // Backpressure generator: holds res_ready low for several cycles per result.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!stall_en) begin
        res_ready = 1'b1;
      end else if (res_valid0 && !res_ready) begin
        if (stall_cnt >= 4) res_ready = 1'b1;
        else stall_cnt++;
      end else begin
        res_ready = 1'b0;
        stall_cnt = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic write_mat(input logic [1:0] a, input logic [W-1:0] d);
    mat_wr_en   = 1'b1;
    mat_wr_addr = a;
    mat_wr_data = d;
    tick();
    mat_wr_en   = 1'b0;
  endtask

  task automatic load_mat(input logic [W-1:0] m0, m1, m2, m3);
    write_mat(2'd0, m0);
    write_mat(2'd1, m1);
    write_mat(2'd2, m2);
    write_mat(2'd3, m3);
  endtask

  // Returns one tick after the final vector handshake edge.
  task automatic send_vec(input logic [W-1:0] a, b, input bit push,
                          input logic [ACC_W-1:0] x0, x1, y0, y1,
                          input bit wr = 1'b0, input logic [1:0] wa = '0,
                          input logic [W-1:0] wd = '0);
    int t;
    for (int i = 0; i < N; i++) begin
      vec_valid = 1'b1;
      vec_data  = (i == 0) ? a : b;
      if (i == 0 && wr) begin
        mat_wr_en   = 1'b1;
        mat_wr_addr = wa;
        mat_wr_data = wd;
      end
      t = 0;
      while (!vec_ready0 && t < 100) begin
        tick();
        t++;
      end
      if (!vec_ready0) begin
        checks++;
        errors++;
        $display("FAIL vec_timeout: vec_ready got 0 expected 1");
      end
      tick();
      mat_wr_en = 1'b0;
    end
    vec_valid = 1'b0;
    if (push) begin
      q0.push_back(exp_t'{d: x0, l: 1'b0});
      q0.push_back(exp_t'{d: x1, l: 1'b1});
      q1.push_back(exp_t'{d: y0, l: 1'b0});
      q1.push_back(exp_t'{d: y1, l: 1'b1});
    end
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((q0.size() != 0 || q1.size() != 0 || !vec_ready0) && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (q0.size() != 0 || q1.size() != 0 || !vec_ready0) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: pending got %0d expected 0", q0.size() + q1.size());
    end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: sim time got %0t expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int h;
    hs[0] = 0;
    hs[1] = 0;

    do_reset();
    tick();
    @(negedge clk);
    check("rst_vec_ready", 32'(vec_ready0), 32'(1));
    check("rst_res_valid", 32'({res_valid0, res_valid1}), 32'(0));
    check("rst_res_last", 32'({res_last0, res_last1}), 32'(0));
    check("rst_busy", 32'({busy0, busy1}), 32'(0));
    check("rst_wr_err", 32'({wr_err0, wr_err1}), 32'(0));
    check("rst_res_data", 32'(res_data0), 32'(0));

    // Basic pass with latency probe
    load_mat(4'd1, 4'd2, 4'd3, 4'd4);
    send_vec(4'd5, 4'd6, 1'b1, 9'd17, 9'd39, 9'd17, 9'd39);
    check("busy_mac", 32'(busy0), 32'(1));
    @(negedge clk) check("lat_c1", 32'(res_valid0), 32'(0));
    @(negedge clk) check("lat_c2", 32'(res_valid0), 32'(0));
    @(negedge clk) check("lat_c3", 32'(res_valid0), 32'(1));
    wait_idle();

    // Same pass under backpressure
    h = hs[0];
    stall_en = 1'b1;
    send_vec(4'd5, 4'd6, 1'b1, 9'd17, 9'd39, 9'd17, 9'd39);
    wait_idle();
    stall_en = 1'b0;
    check("stall_hs_count", 32'(hs[0] - h), 32'(2));
    tick();

    // Full-scale operands
    load_mat(4'd15, 4'd15, 4'd15, 4'd15);
    send_vec(4'd15, 4'd15, 1'b1, 9'd450, 9'd450, 9'd2, 9'd2);
    wait_idle();

    // Most negative signed operand
    load_mat(4'h8, 4'h8, 4'h8, 4'h8);
    send_vec(4'h8, 4'h8, 1'b1, 9'h080, 9'h080, 9'h080, 9'h080);
    wait_idle();

    // Mixed signs; last matrix write shares a cycle with the first vector element
    write_mat(2'd0, 4'hF);
    write_mat(2'd1, 4'h0);
    write_mat(2'd2, 4'h0);
    send_vec(4'd3, 4'hE, 1'b1, 9'd45, 9'd14, 9'h1FD, 9'h1FE, 1'b1, 2'd3, 4'd1);
    wait_idle();

    // Dropped write during S_MAC
    load_mat(4'd1, 4'd2, 4'd3, 4'd4);
    send_vec(4'd5, 4'd6, 1'b1, 9'd17, 9'd39, 9'd17, 9'd39);
    write_mat(2'd0, 4'd9);
    @(negedge clk);
    check("wr_err_set", 32'({wr_err0, wr_err1}), 32'(3));
    wait_idle();
    send_vec(4'd5, 4'd6, 1'b1, 9'd17, 9'd39, 9'd17, 9'd39);
    wait_idle();
    check("wr_err_sticky", 32'(wr_err0), 32'(1));
    do_reset();
    @(negedge clk);
    check("wr_err_clr", 32'(wr_err0), 32'(0));

    // Reset during row 0 of S_MAC aborts the pass
    load_mat(4'd1, 4'd2, 4'd3, 4'd4);
    send_vec(4'd5, 4'd6, 1'b0, 9'd0, 9'd0, 9'd0, 9'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("abort_no_valid", 32'({res_valid0, res_valid1}), 32'(0));
    end
    send_vec(4'd1, 4'd1, 1'b1, 9'd0, 9'd0, 9'd0, 9'd0);
    wait_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
